// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Purpose  : Two-entry skid-buffered pipeline stage with a registered in_ready.
//            Define PIPE_STAGE_BUBBLE_CNT_EN to add the bubble_cnt output.
// Revision : 1.0
// ============================================================================
module pipe_stage_skid #(
  parameter int                PC_W     = 32,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [DATA_W-1:0] instr_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   pc_out,
  output logic [DATA_W-1:0] instr_out
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
  ,
  output logic [31:0]       bubble_cnt
`endif
);

  logic              main_valid_q, main_valid_d;
  logic [PC_W-1:0]   main_pc_q,    main_pc_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [PC_W-1:0]   skid_pc_q,    skid_pc_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic              in_xfer;
  logic              out_xfer;

  // in_ready comes straight from a flop, so it never sees out_ready.
  assign in_ready  = ~skid_valid_q;
  assign in_xfer   = in_valid & ~skid_valid_q;
  assign out_xfer  = main_valid_q & out_ready;

  assign out_valid = main_valid_q;
  assign pc_out    = main_pc_q;
  assign instr_out = main_data_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_pc_d    = main_pc_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_data_d  = skid_data_q;

    if (skid_valid_q) begin
      if (out_xfer) begin
        main_pc_d    = skid_pc_q;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q || out_xfer) begin
      if (in_xfer) begin
        main_valid_d = 1'b1;
        main_pc_d    = pc_in;
        main_data_d  = instr_in;
      end else if (out_xfer) begin
        // Draining: payload reverts to NOP, PC keeps its last value.
        main_valid_d = 1'b0;
        main_data_d  = NOP_WORD;
      end
    end else if (in_xfer) begin
      skid_valid_d = 1'b1;
      skid_pc_d    = pc_in;
      skid_data_d  = instr_in;
    end

    if (flush) begin
      main_valid_d = 1'b0;
      main_pc_d    = '0;
      main_data_d  = NOP_WORD;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_pc_q    <= '0;
      main_data_q  <= NOP_WORD;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_pc_q    <= main_pc_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_data_q  <= skid_data_d;
    end
  end

`ifdef PIPE_STAGE_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q;
  logic [31:0] bubble_cnt_d;

  // Counts idle output cycles; flush deliberately does not clear it.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!main_valid_q && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// Bench for pipe_stage_skid: default instance plus a PC_W=16/DATA_W=64/NOP=0x13
// instance, both checked every cycle against a 2-deep FIFO model.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] pc_in;
  logic [31:0] instr_in;

  logic        in_ready,  out_valid;
  logic [31:0] pc_out,    instr_out;
  logic        in_ready2, out_valid2;
  logic [15:0] pc_out2;
  logic [63:0] instr_out2;
  logic [15:0] pc_in2;
  logic [63:0] instr_in2;
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt, bubble_cnt2;
`endif

  assign pc_in2    = pc_in[15:0];
  assign instr_in2 = {32'h0, instr_in};

  always #5 clk = ~clk;

  pipe_stage_skid dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .instr_in(instr_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .instr_out(instr_out)
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  pipe_stage_skid #(.PC_W(16), .DATA_W(64), .NOP_WORD(64'h13)) dut_w (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2),
    .pc_in(pc_in2), .instr_in(instr_in2),
    .out_valid(out_valid2), .out_ready(out_ready),
    .pc_out(pc_out2), .instr_out(instr_out2)
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
    , .bubble_cnt(bubble_cnt2)
`endif
  );

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Model: the stage behaves as a FIFO of depth two whose head is the output.
  typedef struct packed { logic [31:0] pc; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc_hold = '0;
  logic [31:0] m_bub = '0;
  bit          m_was_valid;
  bit          m_can_take;

  always @(posedge clk) begin
    m_was_valid = (mq.size() > 0);
    m_can_take  = (mq.size() < 2);
    if (rst) begin
      mq.delete();
      m_pc_hold = '0;
      m_bub     = '0;
    end else begin
      if (!m_was_valid && m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 32'd1;
      if (flush) begin
        mq.delete();
        m_pc_hold = '0;
      end else begin
        if (m_was_valid && out_ready) void'(mq.pop_front());
        if (in_valid && m_can_take) mq.push_back({pc_in, instr_in});
        if (mq.size() > 0) m_pc_hold = mq[0].pc;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", {63'h0, out_valid}, {63'h0, mq.size() > 0});
      chk("in_ready",  {63'h0, in_ready},  {63'h0, mq.size() < 2});
      chk("pc_out",    {32'h0, pc_out},    {32'h0, m_pc_hold});
      chk("instr_out", {32'h0, instr_out}, (mq.size() > 0) ? {32'h0, mq[0].data} : 64'h0);
      chk("w_out_valid", {63'h0, out_valid2}, {63'h0, mq.size() > 0});
      chk("w_in_ready",  {63'h0, in_ready2},  {63'h0, mq.size() < 2});
      chk("w_pc_out",    {48'h0, pc_out2},    {48'h0, m_pc_hold[15:0]});
      chk("w_instr_out", instr_out2, (mq.size() > 0) ? {32'h0, mq[0].data} : 64'h13);
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
      chk("bubble_cnt",   {32'h0, bubble_cnt},  {32'h0, m_bub});
      chk("w_bubble_cnt", {32'h0, bubble_cnt2}, {32'h0, m_bub});
`endif
    end
  end

  task automatic drive(input bit iv, input logic [31:0] pc);
    in_valid = iv;
    pc_in    = pc;
    instr_in = pc ^ 32'h5A5A_0001;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0);
    @(negedge clk);
    step(); step();
    started = 1'b1;
    rst = 1'b0;
    chk("rst_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_ready", {63'h0, in_ready}, 64'h1);
    chk("rst_pc", {32'h0, pc_out}, 64'h0);
    chk("rst_instr_w", instr_out2, 64'h13);

    repeat (5) step();
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
    chk("bub_idle5", {32'h0, bubble_cnt}, 64'd5);
    flush = 1'b1; step(); flush = 1'b0;
    chk("bub_flush_kept", {32'h0, bubble_cnt}, 64'd6);
`endif

    // Streaming: one entry per cycle, one-cycle latency.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'(4 * i));
      step();
      chk("stream_valid", {63'h0, out_valid}, 64'h1);
      chk("stream_pc", {32'h0, pc_out}, 64'(4 * i));
      chk("stream_pc_w", {48'h0, pc_out2}, 64'(4 * i));
    end
    drive(1'b0, 32'h0);
    step();
    chk("drain_valid", {63'h0, out_valid}, 64'h0);
    chk("drain_instr", {32'h0, instr_out}, 64'h0);

    // Backpressure into the skid register.
    out_ready = 1'b0;
    drive(1'b1, 32'h10); step();
    chk("bp_pc10", {32'h0, pc_out}, 64'h10);
    drive(1'b1, 32'h14); step();
    chk("bp_ready0", {63'h0, in_ready}, 64'h0);
    chk("bp_hold10", {32'h0, pc_out}, 64'h10);
    out_ready = 1'b1;
    drive(1'b1, 32'h18); step();
    chk("bp_pc14", {32'h0, pc_out}, 64'h14);
    chk("bp_ready1", {63'h0, in_ready}, 64'h1);
    drive(1'b0, 32'h0); step();
    chk("bp_empty", {63'h0, out_valid}, 64'h0);

    // Flush with both entries full; 0x40 must never appear.
    out_ready = 1'b0;
    drive(1'b1, 32'h20); step();
    drive(1'b1, 32'h24); step();
    flush = 1'b1; drive(1'b1, 32'h40); step(); flush = 1'b0;
    chk("fl_valid", {63'h0, out_valid}, 64'h0);
    chk("fl_instr", {32'h0, instr_out}, 64'h0);
    chk("fl_instr_w", instr_out2, 64'h13);
    chk("fl_pc", {32'h0, pc_out}, 64'h0);
    out_ready = 1'b1; drive(1'b0, 32'h0); step();
    chk("fl_no40", {63'h0, out_valid}, 64'h0);
    // Flush while in_ready=1: the offered entry is still dropped.
    out_ready = 1'b0;
    drive(1'b1, 32'h28); step();
    flush = 1'b1; drive(1'b1, 32'h44); step(); flush = 1'b0;
    drive(1'b0, 32'h0); step();
    chk("fl_no44", {63'h0, out_valid}, 64'h0);

    // Reset with the skid register full and traffic in flight.
    drive(1'b1, 32'h30); step();
    drive(1'b1, 32'h34); step();
    chk("rs_full", {63'h0, in_ready}, 64'h0);
    rst = 1'b1; out_ready = 1'b1; drive(1'b1, 32'h38); step();
    rst = 1'b0; drive(1'b0, 32'h0);
    chk("rs_valid", {63'h0, out_valid}, 64'h0);
    chk("rs_ready", {63'h0, in_ready}, 64'h1);
    chk("rs_pc", {32'h0, pc_out}, 64'h0);
    chk("rs_instr_w", instr_out2, 64'h13);

    // Mixed valid/ready patterns with a flush in the middle.
    for (int i = 0; i < 48; i++) begin
      drive((i % 3) != 2, 32'(32'h100 + 4 * i));
      out_ready = (i % 5) < 3;
      flush = (i == 30);
      step();
    end
    flush = 1'b0; out_ready = 1'b1; drive(1'b0, 32'h0);
    repeat (3) step();
    chk("end_empty", {63'h0, out_valid}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
